// File: rtl/inst_rom_resp_if.sv
// Fetch-port bundle between the core (master) and the instruction ROM responder (slave).
interface inst_rom_resp_if;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        rom_valid_o;
  logic        stallreq_o;
  logic        rom_perr_o;

  modport master (output rom_ce_i, rom_addr_i,
                  input  rom_data_o, rom_valid_o, stallreq_o, rom_perr_o);
  modport slave  (input  rom_ce_i, rom_addr_i,
                  output rom_data_o, rom_valid_o, stallreq_o, rom_perr_o);
endinterface

// File: rtl/inst_rom_resp.sv
// Instruction ROM responder: fixed-latency word reads, stall request, byte-serial loader.
// Optional feature: define ROM_PARITY_EN for a 33-bit array with even parity checked on every read.
module inst_rom_resp #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_rom_resp_if.slave       bus,
  input  logic                 ld_en_i,
  input  logic [7:0]           ld_byte_i,
  input  logic                 ld_byte_valid_i,
  output logic [ADDR_W:0]      ld_words_o,
  output logic                 ld_full_o
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef ROM_PARITY_EN
  localparam int MEM_W = 33;
`else
  localparam int MEM_W = 32;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       latCnt_q, latCnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic [1:0]       byteCnt_q, byteCnt_d;
  logic [23:0]      byteBuf_q, byteBuf_d;
  logic [ADDR_W:0]  wordCnt_q, wordCnt_d;
  logic             full_q, full_d;
  logic [MEM_W-1:0] mem_q [DEPTH];

  logic [31:0]      rdAddr;
  logic             rdOob;
  logic [MEM_W-1:0] rdWord;
  logic             rdFire;
  logic             wrEn;
  logic [31:0]      wrWord;
  logic [MEM_W-1:0] wrMem;
  logic             unusedAddrBits;

  // A latency-1 read uses the live address; longer reads use the address latched at acceptance.
  assign rdAddr         = (state_q == BUSY) ? addr_q : bus.rom_addr_i;
  assign rdOob          = |rdAddr[31:ADDR_W+2];
  assign rdWord         = mem_q[rdAddr[ADDR_W+1:2]];
  assign unusedAddrBits = ^rdAddr[1:0];
  assign wrWord         = {ld_byte_i, byteBuf_q};

`ifdef ROM_PARITY_EN
  logic perr_q, perr_d;
  assign wrMem          = {^wrWord, wrWord};
  assign bus.rom_perr_o = perr_q;
`else
  assign wrMem          = wrWord;
  assign bus.rom_perr_o = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    latCnt_d  = latCnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    byteCnt_d = byteCnt_q;
    byteBuf_d = byteBuf_q;
    wordCnt_d = wordCnt_q;
    full_d    = full_q;
    rdFire    = 1'b0;
    wrEn      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_en_i) begin
          state_d   = LOAD;
          wordCnt_d = '0;
          full_d    = 1'b0;
          byteCnt_d = '0;
        end else if (bus.rom_ce_i) begin
          addr_d = bus.rom_addr_i;
          if (READ_LAT == 1) begin
            rdFire = 1'b1;
          end else begin
            latCnt_d = 2'(READ_LAT - 1);
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        if (latCnt_q == 2'd1) begin
          rdFire  = 1'b1;
          state_d = IDLE;
        end else begin
          latCnt_d = latCnt_q - 2'd1;
        end
      end
      LOAD: begin
        if (!ld_en_i) begin
          state_d   = IDLE;
          byteCnt_d = '0;
        end else if (ld_byte_valid_i && !full_q) begin
          if (byteCnt_q == 2'd3) begin
            wrEn      = 1'b1;
            byteCnt_d = '0;
            wordCnt_d = wordCnt_q + (ADDR_W+1)'(1);
            // The counter saturates at DEPTH, so its top bit alone marks a full array.
            full_d    = wordCnt_d[ADDR_W];
          end else begin
            byteBuf_d = {ld_byte_i, byteBuf_q[23:8]};
            byteCnt_d = byteCnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rdFire) begin
      valid_d = 1'b1;
      data_d  = rdOob ? 32'h0 : rdWord[31:0];
    end
  end

`ifdef ROM_PARITY_EN
  assign perr_d = rdFire & ~rdOob & (^rdWord);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      latCnt_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      byteCnt_q <= '0;
      byteBuf_q <= '0;
      wordCnt_q <= '0;
      full_q    <= 1'b0;
`ifdef ROM_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      latCnt_q  <= latCnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      byteCnt_q <= byteCnt_d;
      byteBuf_q <= byteBuf_d;
      wordCnt_q <= wordCnt_d;
      full_q    <= full_d;
`ifdef ROM_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  // Array has no reset so loaded code survives a core reset.
  always_ff @(posedge clk) begin
    if (wrEn) mem_q[wordCnt_q[ADDR_W-1:0]] <= wrMem;
  end

  assign bus.rom_data_o  = data_q;
  assign bus.rom_valid_o = valid_q;
  assign bus.stallreq_o  = (state_q == BUSY)
                         | ((state_q == IDLE) & bus.rom_ce_i & (READ_LAT > 1))
                         | ((state_q == LOAD) & bus.rom_ce_i);
  assign ld_words_o      = wordCnt_q;
  assign ld_full_o       = full_q;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Randomized bench for inst_rom_resp: two instances (ADDR_W=4/READ_LAT=3 and ADDR_W=2/READ_LAT=1)
// share the loader and are checked against a transaction-level memory model.
module tb_inst_rom_resp;
  logic       clk = 1'b0;
  logic       rst;
  logic       ldEn;
  logic       ldByteValid;
  logic [7:0] ldByte;
  logic [4:0] ldWordsA;
  logic       ldFullA;
  logic [2:0] ldWordsB;
  logic       ldFullB;

  inst_rom_resp_if ifA ();
  inst_rom_resp_if ifB ();

  inst_rom_resp #(.ADDR_W(4), .READ_LAT(3)) dutA (
    .clk(clk), .rst(rst), .bus(ifA.slave), .ld_en_i(ldEn), .ld_byte_i(ldByte),
    .ld_byte_valid_i(ldByteValid), .ld_words_o(ldWordsA), .ld_full_o(ldFullA));

  inst_rom_resp #(.ADDR_W(2), .READ_LAT(1)) dutB (
    .clk(clk), .rst(rst), .bus(ifB.slave), .ld_en_i(ldEn), .ld_byte_i(ldByte),
    .ld_byte_valid_i(ldByteValid), .ld_words_o(ldWordsB), .ld_full_o(ldFullB));

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] memM [2][16];
  bit          flipM [2][16];
  int          wordsM [2];
  bit          fullM [2];
  int          pCnt [2];
  logic [31:0] pAcc [2];
  logic [31:0] dataM [2];
  int          awM [2] = '{4, 2};
  int          latM [2] = '{3, 1};
  logic [7:0]  byteQ [$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obsData(int d);
    return (d == 0) ? ifA.rom_data_o : ifB.rom_data_o;
  endfunction
  function automatic logic obsValid(int d);
    return (d == 0) ? ifA.rom_valid_o : ifB.rom_valid_o;
  endfunction
  function automatic logic obsStall(int d);
    return (d == 0) ? ifA.stallreq_o : ifB.stallreq_o;
  endfunction
  function automatic logic obsPerr(int d);
    return (d == 0) ? ifA.rom_perr_o : ifB.rom_perr_o;
  endfunction
  function automatic logic [31:0] obsWords(int d);
    return (d == 0) ? 32'(ldWordsA) : 32'(ldWordsB);
  endfunction
  function automatic logic obsFull(int d);
    return (d == 0) ? ldFullA : ldFullB;
  endfunction

  function automatic bit isOob(int d, logic [31:0] a);
    return (a >> (awM[d] + 2)) != 0;
  endfunction
  function automatic int wIdx(int d, logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << awM[d]) - 1));
  endfunction

  task automatic modelByte(input int d, input logic [7:0] b);
    if (fullM[d]) return;
    pAcc[d] = pAcc[d] | (32'(b) << (8 * pCnt[d]));
    pCnt[d]++;
    if (pCnt[d] == 4) begin
      memM[d][wordsM[d]]  = pAcc[d];
      flipM[d][wordsM[d]] = 1'b0;
      wordsM[d]++;
      fullM[d] = (wordsM[d] == (1 << awM[d]));
      pCnt[d]  = 0;
      pAcc[d]  = '0;
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s.data[%0d]", tag, d), obsData(d), dataM[d]);
      checkOutput($sformatf("%s.valid[%0d]", tag, d), obsValid(d), 0);
      checkOutput($sformatf("%s.stall[%0d]", tag, d), obsStall(d), 0);
      checkOutput($sformatf("%s.words[%0d]", tag, d), obsWords(d), 32'(wordsM[d]));
      checkOutput($sformatf("%s.full[%0d]", tag, d), obsFull(d), fullM[d]);
      checkOutput($sformatf("%s.perr[%0d]", tag, d), obsPerr(d), 0);
    end
  endtask

  task automatic applyLoad(input int nBytes, input bit gaps);
    logic [7:0] b;
    @(negedge clk);
    ldEn = 1'b1;
    ldByteValid = 1'b0;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      wordsM[d] = 0; fullM[d] = 1'b0; pCnt[d] = 0; pAcc[d] = '0;
    end
    for (int i = 0; i < nBytes; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        ldByteValid = 1'b0;
        ifA.rom_ce_i = 1'b0;
        ifB.rom_ce_i = 1'b0;
        @(posedge clk);
      end
      @(negedge clk);
      b = (byteQ.size() > 0) ? byteQ.pop_front() : 8'($urandom);
      ldByte = b;
      ldByteValid = 1'b1;
      ifA.rom_ce_i = (i == 0);
      ifB.rom_ce_i = (i == 0);
      #1;
      if (i == 0) begin
        checkOutput("loadStall[0]", obsStall(0), 1);
        checkOutput("loadStall[1]", obsStall(1), 1);
      end
      checkOutput("loadNoValid[0]", obsValid(0), 0);
      checkOutput("loadNoValid[1]", obsValid(1), 0);
      @(posedge clk);
      for (int d = 0; d < 2; d++) modelByte(d, b);
    end
    @(negedge clk);
    ldByteValid = 1'b0;
    ldEn = 1'b0;
    ifA.rom_ce_i = 1'b0;
    ifB.rom_ce_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("afterLoad");
  endtask

  task automatic applyFetch(input logic [31:0] a, input bit noise);
    logic [31:0] e [2];
    bit          p [2];
    bit          v;
    @(negedge clk);
    ifA.rom_ce_i = 1'b1; ifA.rom_addr_i = a;
    ifB.rom_ce_i = 1'b1; ifB.rom_addr_i = a;
    for (int d = 0; d < 2; d++) begin
      e[d] = isOob(d, a) ? 32'h0 : memM[d][wIdx(d, a)];
      p[d] = !isOob(d, a) && flipM[d][wIdx(d, a)];
    end
    #1;
    checkOutput("preStall[0]", obsStall(0), 1);
    checkOutput("preStall[1]", obsStall(1), 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        v = (k == latM[d] - 1);
        if (v) dataM[d] = e[d];
        checkOutput($sformatf("fetchValid[%0d]k%0d", d, k), obsValid(d), v);
        checkOutput($sformatf("fetchData[%0d]k%0d", d, k), obsData(d), dataM[d]);
        checkOutput($sformatf("fetchPerr[%0d]k%0d", d, k), obsPerr(d), v && p[d]);
        checkOutput($sformatf("fetchStall[%0d]k%0d", d, k), obsStall(d), (d == 0) && (k < latM[0] - 1));
      end
      if (k == 0) begin
        ifB.rom_ce_i = 1'b0;
        ifA.rom_ce_i = noise;
        ifA.rom_addr_i = $urandom;
      end
      if (k == 1) ifA.rom_ce_i = 1'b0;
    end
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, 63));
      2:       return 32'h40 | 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic applyStimulus();
    if ($urandom_range(0, 9) < 7) applyFetch(randAddr(), 1'($urandom_range(0, 1)));
    else                          applyLoad($urandom_range(0, 20), 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ldEn = 1'b0; ldByteValid = 1'b0; ldByte = '0;
    ifA.rom_ce_i = 1'b0; ifA.rom_addr_i = '0;
    ifB.rom_ce_i = 1'b0; ifB.rom_addr_i = '0;
    for (int d = 0; d < 2; d++) begin
      dataM[d] = '0; wordsM[d] = 0; fullM[d] = 1'b0; pCnt[d] = 0; pAcc[d] = '0;
      for (int w = 0; w < 16; w++) begin memM[d][w] = '0; flipM[d][w] = 1'b0; end
    end
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b1;

    // Fill both arrays completely; the narrow instance goes full after 16 bytes.
    byteQ = '{8'h13, 8'h00, 8'h01, 8'h34};
    applyLoad(65, 1'b0);
    applyFetch(32'h0, 1'b0);
    checkOutput("word0A", ifA.rom_data_o, 32'h34010013);
    checkOutput("word0B", ifB.rom_data_o, 32'h34010013);
    applyFetch(32'h3E, 1'b1);
    applyFetch(32'h40, 1'b0);
    applyFetch(32'h4, 1'b1);

    applyLoad(2, 1'b0);
    applyFetch(32'h0, 1'b0);
    applyLoad(17, 1'b1);
    applyFetch(32'hC, 1'b0);

    for (int i = 0; i < 40; i++) applyStimulus();

    // Reset while instance A is mid-read: the read must vanish, loaded words must survive.
    @(negedge clk);
    ifA.rom_ce_i = 1'b1; ifA.rom_addr_i = 32'h4;
    @(posedge clk);
    @(negedge clk);
    ifA.rom_ce_i = 1'b0;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      dataM[d] = '0; wordsM[d] = 0; fullM[d] = 1'b0; pCnt[d] = 0; pAcc[d] = '0;
    end
    #1;
    checkIdleOutputs("midReadReset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("noValidAfterReset", obsValid(0), 0);
    end
    applyFetch(32'h4, 1'b0);

`ifdef ROM_PARITY_EN
    @(negedge clk);
    dutA.mem_q[2] = dutA.mem_q[2] ^ 33'h4;
    memM[0][2] = memM[0][2] ^ 32'h4;
    flipM[0][2] = 1'b1;
    applyFetch(32'h8, 1'b0);
    applyFetch(32'hC, 1'b0);
`endif

    for (int i = 0; i < 20; i++) applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
